// File: rtl/work_loader_pkg.sv
// Shared types and constants for the work loader and the downstream core.
package work_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam int WORDS_MID   = 8;
  localparam int WORDS_HEAD  = 16;
  localparam int WORDS_TOTAL = WORDS_MID + WORDS_HEAD;

endpackage

// File: rtl/work_loader_byte_to_word.sv
// Packs accepted payload bytes big-endian into 32-bit words and pulses word_ready
// in the cycle after the fourth byte of each word arrives.
module byte_to_word
  import work_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic [31:0] word_data,
  output logic        word_ready
);

  logic [1:0]  byte_cnt;
  logic [23:0] partial;

  assign last_byte = (byte_cnt == 2'd3);

  // Collect three bytes, then publish the full word with a one-cycle ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      partial    <= 24'd0;
      word_data  <= 32'd0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        byte_cnt <= 2'd0;
        partial  <= 24'd0;
      end else if (byte_valid) begin
        if (last_byte) begin
          word_data  <= {partial, byte_data};
          word_ready <= 1'b1;
          byte_cnt   <= 2'd0;
        end else begin
          partial  <= {partial[15:0], byte_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/work_loader.sv
// Frame receiver: hunts for the sync byte, streams 24 payload words to the
// downstream core, verifies the XOR checksum and aborts on an idle timeout.
module work_loader
  import work_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        start_found,
  output logic [31:0] in_data,
  output logic        shift_in_enable,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int              TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [4:0]      LAST_WORD = 5'(WORDS_TOTAL - 1);

  state_t            state;
  state_t            next_state;
  logic [4:0]        word_cnt;
  logic [7:0]        checksum;
  logic [TMO_W-1:0]  tmo;
  logic [TMO_W-1:0]  tmo_next;
  logic              accept;
  logic              load_accept;
  logic              counting;
  logic              timeout;
  logic              last_byte;
  logic              word_ready;
  logic [31:0]       word_data;

  // The reset term keeps rx_ready low for the whole reset, even before the state settles.
  assign rx_ready    = !n_rst && (state inside {IDLE, LOAD, CHECK});
  assign accept      = rx_valid && rx_ready;
  assign load_accept = accept && (state == LOAD);
  assign counting    = (state == LOAD) || (state == CHECK);
  assign timeout     = counting && (tmo_next == TMO_LIMIT);

  byte_to_word u_byte_to_word (
    .clk        (clk),
    .rst        (n_rst),
    .clear      (state == START),
    .byte_valid (load_accept),
    .byte_data  (rx_data),
    .last_byte  (last_byte),
    .word_data  (word_data),
    .word_ready (word_ready)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (n_rst) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decision from the handshake, word position, checksum and idle timer.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (accept && rx_data == SYNC_BYTE) next_state = START;
      START: next_state = LOAD;
      LOAD: begin
        if (timeout) next_state = ERR;
        else if (load_accept && last_byte && word_cnt == LAST_WORD) next_state = CHECK;
      end
      CHECK: begin
        if (accept) next_state = (rx_data == checksum) ? DONE : ERR;
        else if (timeout) next_state = ERR;
      end
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Idle timer candidate value: restarts on every accepted byte.
  always_comb begin
    tmo_next = tmo + TMO_W'(1);
    if (accept) tmo_next = '0;
  end

  // Idle timer only runs while a frame is being received.
  always_ff @(posedge clk) begin
    if (n_rst)         tmo <= '0;
    else if (counting) tmo <= tmo_next;
    else               tmo <= '0;
  end

  // Word counter stops at the last word rather than wrapping.
  always_ff @(posedge clk) begin
    if (n_rst || state == START) word_cnt <= 5'd0;
    else if (load_accept && last_byte && word_cnt != LAST_WORD) word_cnt <= word_cnt + 5'd1;
  end

  // Running XOR over the payload bytes only.
  always_ff @(posedge clk) begin
    if (n_rst || state == START) checksum <= 8'd0;
    else if (load_accept)        checksum <= checksum ^ rx_data;
  end

  assign start_found     = !n_rst && (state == START);
  assign frame_done      = !n_rst && (state == DONE);
  assign frame_err       = !n_rst && (state == ERR);
  assign busy            = !n_rst && (state != IDLE);
  assign shift_in_enable = !n_rst && word_ready;
  assign in_data         = n_rst ? 32'd0 : word_data;

endmodule

// File: tb/tb_work_loader.sv
// Randomized bench for work_loader with a frame-level reference model.
module tb_work_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 16;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        start_found;
  logic [31:0] in_data;
  logic        shift_in_enable;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  work_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .start_found     (start_found),
    .in_data         (in_data),
    .shift_in_enable (shift_in_enable),
    .frame_done      (frame_done),
    .frame_err       (frame_err),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Observation counters kept by the monitor.
  int          cyc = 0;
  int          startSeen = 0;
  int          doneSeen = 0;
  int          errSeen = 0;
  int          readyLow = 0;
  int          lastAccCycle = 0;
  int          errCycle = 0;
  logic [31:0] obsWords[$];

  // Reference model state: a frame is hunt -> 96 payload bytes -> checksum byte.
  int          mPhase = 0;
  int          mCount = 0;
  int          mLast = 0;
  logic [7:0]  mXor = 8'd0;
  logic [31:0] mShift = 32'd0;
  logic [31:0] mWord = 32'd0;
  logic [31:0] pWord = 32'd0;
  logic pStart = 0, pShift = 0, pDone = 0, pErr = 0, pBlock = 0;
  logic eStart, eShift, eDone, eErr, eReady, eBusy, blocked, acc;

  logic [7:0] frameBytes[96];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Every cycle: record what the DUT did, advance the model, compare.
  always @(negedge clk) begin
    if (start_found) begin
      startSeen++;
      obsWords.delete();
    end
    if (shift_in_enable) obsWords.push_back(in_data);
    if (frame_done) doneSeen++;
    if (frame_err) begin
      errSeen++;
      errCycle = cyc;
    end
    if (rx_valid && rx_ready) lastAccCycle = cyc;
    if (rx_valid && !rx_ready && !n_rst) readyLow++;

    eStart = pStart; eShift = pShift; eDone = pDone; eErr = pErr; blocked = pBlock;
    if (pShift) mWord = pWord;
    pStart = 0; pShift = 0; pDone = 0; pErr = 0; pBlock = 0;

    if (n_rst) begin
      mPhase = 0; mWord = 32'd0;
      eStart = 0; eShift = 0; eDone = 0; eErr = 0; eReady = 0; eBusy = 0;
    end else begin
      eReady = !blocked;
      eBusy  = blocked || (mPhase != 0);
      acc    = rx_valid && eReady;
      case (mPhase)
        0: if (acc && rx_data == SYNC) begin
          pStart = 1; pBlock = 1; mPhase = 1; mCount = 0; mXor = 8'd0; mLast = cyc + 1;
        end
        1: if (acc) begin
          mCount++;
          mXor   = mXor ^ rx_data;
          mShift = {mShift[23:0], rx_data};
          if (mCount % 4 == 0) begin pShift = 1; pWord = mShift; end
          if (mCount == 96) mPhase = 2;
          mLast = cyc;
        end else if (cyc - mLast == TMO) begin
          pErr = 1; pBlock = 1; mPhase = 0;
        end
        default: if (acc) begin
          if (rx_data == mXor) pDone = 1; else pErr = 1;
          pBlock = 1; mPhase = 0;
        end else if (cyc - mLast == TMO) begin
          pErr = 1; pBlock = 1; mPhase = 0;
        end
      endcase
    end

    checkOutput("ctrl", {26'd0, rx_ready, busy, start_found, shift_in_enable, frame_done, frame_err},
                {26'd0, eReady, eBusy, eStart, eShift, eDone, eErr});
    checkOutput("in_data", in_data, mWord);
    cyc++;
  end

  task automatic waitCycles(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one byte after an idle gap and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [7:0] d, input int gap);
    int   w;
    logic ok;
    if (gap > 0) waitCycles(gap);
    rx_data  = d;
    rx_valid = 1'b1;
    ok = 1'b0;
    w  = 0;
    while (!ok && w < 64) begin
      @(negedge clk);
      ok = rx_ready;
      if (!ok) begin @(posedge clk); #1; w++; end
    end
    checkOutput("handshake", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendPayload(input logic [7:0] csum, input int maxGap);
    for (int i = 0; i < 96; i++) applyStimulus(frameBytes[i], $urandom_range(maxGap, 0));
    applyStimulus(csum, $urandom_range(maxGap, 0));
  endtask

  task automatic randomPayload();
    for (int i = 0; i < 96; i++) frameBytes[i] = 8'($urandom_range(255, 0));
  endtask

  function automatic logic [7:0] payloadXor();
    logic [7:0] x = 8'd0;
    for (int i = 0; i < 96; i++) x = x ^ frameBytes[i];
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, e0, s0, r0;
    logic [7:0] junk;
    logic good;

    n_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("reset_outputs", {26'd0, rx_ready, busy, start_found, shift_in_enable, frame_done, frame_err}, 32'd0);
    checkOutput("reset_in_data", in_data, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;

    // Junk before sync, then a good frame of 0x00..0x5F.
    applyStimulus(8'h00, 1);
    applyStimulus(8'h11, 0);
    checkOutput("no_start_before_sync", startSeen, 0);
    d0 = doneSeen; e0 = errSeen;
    applyStimulus(SYNC, 0);
    @(negedge clk);
    checkOutput("start_after_sync", {31'd0, start_found}, 32'd1);
    checkOutput("start_ready_low", {31'd0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 96; i++) frameBytes[i] = 8'(i);
    sendPayload(8'h00, 2);
    waitCycles(4);
    checkOutput("good_word_count", obsWords.size(), 24);
    checkOutput("good_first_word", obsWords[0], 32'h00010203);
    checkOutput("good_last_word", obsWords[23], 32'h5C5D5E5F);
    checkOutput("good_done", doneSeen - d0, 1);
    checkOutput("good_err", errSeen - e0, 0);

    // Same frame with a bad checksum.
    d0 = doneSeen; e0 = errSeen;
    applyStimulus(SYNC, 1);
    sendPayload(8'hFF, 2);
    waitCycles(4);
    checkOutput("bad_word_count", obsWords.size(), 24);
    checkOutput("bad_err", errSeen - e0, 1);
    checkOutput("bad_done", doneSeen - d0, 0);
    @(negedge clk);
    checkOutput("bad_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Stall after 10 payload bytes. The error must appear 16 clock edges after the
    // edge that took the last byte, which is cycle index lastAcc + 17.
    e0 = errSeen; s0 = startSeen;
    applyStimulus(SYNC, 0);
    for (int i = 0; i < 10; i++) applyStimulus(8'(8'h40 + i), $urandom_range(3, 0));
    waitCycles(30);
    checkOutput("stall_words", obsWords.size(), 2);
    checkOutput("stall_err", errSeen - e0, 1);
    checkOutput("stall_err_delay", errCycle - lastAccCycle, 17);
    d0 = doneSeen;
    randomPayload();
    applyStimulus(SYNC, 0);
    sendPayload(payloadXor(), 3);
    waitCycles(4);
    checkOutput("stall_restart", startSeen - s0, 2);
    checkOutput("stall_next_done", doneSeen - d0, 1);

    // rx_valid held high through a whole frame, with the sync value as payload.
    d0 = doneSeen; r0 = readyLow;
    randomPayload();
    frameBytes[5] = SYNC;
    applyStimulus(SYNC, 0);
    sendPayload(payloadXor(), 0);
    applyStimulus(8'h3C, 0);
    waitCycles(3);
    checkOutput("stream_ready_low", readyLow - r0, 2);
    checkOutput("stream_words", obsWords.size(), 24);
    checkOutput("stream_sync_data", {24'd0, obsWords[1][23:16]}, {24'd0, SYNC});
    checkOutput("stream_done", doneSeen - d0, 1);

    // Reset in the middle of a frame.
    e0 = errSeen;
    randomPayload();
    applyStimulus(SYNC, 0);
    for (int i = 0; i < 40; i++) applyStimulus(frameBytes[i], $urandom_range(2, 0));
    n_rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_outputs", {26'd0, rx_ready, busy, start_found, shift_in_enable, frame_done, frame_err}, 32'd0);
    checkOutput("midreset_in_data", in_data, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    n_rst = 1'b0;
    waitCycles(20);
    checkOutput("midreset_no_err", errSeen - e0, 0);
    d0 = doneSeen;
    randomPayload();
    applyStimulus(SYNC, 0);
    sendPayload(payloadXor(), 2);
    waitCycles(4);
    checkOutput("midreset_next_done", doneSeen - d0, 1);

    // Random frames with junk in between and random checksum quality.
    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < int'($urandom_range(3, 0)); j++) begin
        junk = 8'($urandom_range(255, 0));
        if (junk == SYNC) junk = 8'h5A;
        applyStimulus(junk, $urandom_range(3, 0));
      end
      d0 = doneSeen; e0 = errSeen;
      good = 1'($urandom_range(1, 0));
      randomPayload();
      applyStimulus(SYNC, $urandom_range(3, 0));
      sendPayload(good ? payloadXor() : (payloadXor() ^ 8'($urandom_range(255, 1))), 4);
      waitCycles(3);
      checkOutput("rand_words", obsWords.size(), 24);
      checkOutput("rand_done", doneSeen - d0, {31'd0, good});
      checkOutput("rand_err", errSeen - e0, {31'd0, !good});
    end

    waitCycles(10);
    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
